// File: rtl/xillybus_loopback_fifo_if.sv
// Handshake bundle between the Xillybus core (master) and the loopback FIFO (slave).
interface xillybus_loopback_fifo_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
);
  logic              user_w_wren;
  logic [DATA_W-1:0] user_w_data;
  logic              user_w_full;
  logic              user_w_open;
  logic              user_r_rden;
  logic [DATA_W-1:0] user_r_data;
  logic              user_r_empty;
  logic              user_r_eof;
  logic              user_r_open;
  logic [ADDR_W:0]   fill_level;
  logic              overflow;

  modport master (
    output user_w_wren, user_w_data, user_w_open,
    output user_r_rden, user_r_open,
    input  user_w_full, user_r_data, user_r_empty, user_r_eof,
    input  fill_level, overflow
  );

  modport slave (
    input  user_w_wren, user_w_data, user_w_open,
    input  user_r_rden, user_r_open,
    output user_w_full, user_r_data, user_r_empty, user_r_eof,
    output fill_level, overflow
  );
endinterface

// File: rtl/xillybus_loopback_fifo.sv
// Loopback FIFO for one Xillybus write/read stream pair, with read-side EOF
// generation once the write file is closed and the buffer has drained.
module xillybus_loopback_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
) (
  input  logic                     bus_clk,
  input  logic                     trn_reset_n,
  xillybus_loopback_fifo_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_EOF
  } state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count, count_next;
  logic              full_q, empty_q, eof_q, ovf_q;
  logic [DATA_W-1:0] rdata_q;
  logic              w_open_q, r_open_q;
  logic              w_rise, w_fall, flush;
  logic              wr_acc, rd_acc;

  assign w_rise = bus.user_w_open & ~w_open_q;
  assign w_fall = ~bus.user_w_open & w_open_q;
  assign flush  = r_open_q & ~bus.user_r_open & ~bus.user_w_open;

  // A flush discards any same-cycle transfer; registered flags make the
  // empty case write-only and the full case read-only without a bypass path.
  assign wr_acc = bus.user_w_wren & ~full_q  & ~flush;
  assign rd_acc = bus.user_r_rden & ~empty_q & ~flush;

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   count_next = count + CNT_ONE;
        2'b01:   count_next = count - CNT_ONE;
        default: count_next = count;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:   if (w_rise) state_next = S_STREAM;
        S_STREAM: if (w_fall) state_next = S_DRAIN;
        S_DRAIN: begin
          if (w_rise)                 state_next = S_STREAM;
          else if (count_next == '0)  state_next = S_EOF;
        end
        S_EOF: begin
          if (w_rise)      state_next = S_STREAM;
          else if (wr_acc) state_next = S_DRAIN;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      eof_q    <= 1'b0;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
      w_open_q <= 1'b0;
      r_open_q <= 1'b0;
    end else begin
      state    <= state_next;
      w_open_q <= bus.user_w_open;
      r_open_q <= bus.user_r_open;
      count    <= count_next;
      full_q   <= (count_next == CNT_FULL);
      empty_q  <= (count_next == '0);
      eof_q    <= (state_next == S_EOF);
      if (bus.user_w_wren && full_q) ovf_q <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_acc) begin
          rd_ptr  <= rd_ptr + PTR_ONE;
          rdata_q <= mem[rd_ptr];
        end
      end
    end
  end

  always_ff @(posedge bus_clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.user_w_data;
  end

  assign bus.user_w_full  = full_q;
  assign bus.user_r_empty = empty_q;
  assign bus.user_r_eof   = eof_q;
  assign bus.user_r_data  = rdata_q;
  assign bus.fill_level   = count;
  assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_xillybus_loopback_fifo.sv
// Directed bench for xillybus_loopback_fifo with a 4-word buffer.
module tb_xillybus_loopback_fifo;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;

  logic bus_clk;
  logic trn_reset_n;
  int   errors;
  int   checks;

  xillybus_loopback_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  xillybus_loopback_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .bus_clk     (bus_clk),
    .trn_reset_n (trn_reset_n),
    .bus         (bus)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d);
    bus.user_w_wren = 1'b1;
    bus.user_w_data = d;
    tick();
    bus.user_w_wren = 1'b0;
  endtask

  task automatic rd();
    bus.user_r_rden = 1'b1;
    tick();
    bus.user_r_rden = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.user_w_wren = 1'b0;
    bus.user_w_data = '0;
    bus.user_w_open = 1'b0;
    bus.user_r_rden = 1'b0;
    bus.user_r_open = 1'b0;
    trn_reset_n = 1'b0;
    repeat (3) tick();

    check_eq("rst_empty", {31'd0, bus.user_r_empty}, 32'd1);
    check_eq("rst_full",  {31'd0, bus.user_w_full},  32'd0);
    check_eq("rst_eof",   {31'd0, bus.user_r_eof},   32'd0);
    check_eq("rst_fill",  {29'd0, bus.fill_level},   32'd0);
    check_eq("rst_data",  bus.user_r_data,           32'd0);

    trn_reset_n = 1'b1;
    tick();
    bus.user_w_open = 1'b1;
    bus.user_r_open = 1'b1;
    tick();

    // Loopback ordering
    wr(32'h11); wr(32'h22); wr(32'h33);
    check_eq("lb_fill3", {29'd0, bus.fill_level}, 32'd3);
    check_eq("lb_nempty", {31'd0, bus.user_r_empty}, 32'd0);
    rd(); check_eq("lb_d0", bus.user_r_data, 32'h11);
    rd(); check_eq("lb_d1", bus.user_r_data, 32'h22);
    rd(); check_eq("lb_d2", bus.user_r_data, 32'h33);
    check_eq("lb_empty", {31'd0, bus.user_r_empty}, 32'd1);
    check_eq("lb_eof", {31'd0, bus.user_r_eof}, 32'd0);

    // Full and overflow
    wr(32'hA1); wr(32'hA2); wr(32'hA3); wr(32'hA4);
    check_eq("full_flag", {31'd0, bus.user_w_full}, 32'd1);
    check_eq("full_fill", {29'd0, bus.fill_level}, 32'd4);
    check_eq("ovf_before", {31'd0, bus.overflow}, 32'd0);
    wr(32'hA5);
    check_eq("ovf_fill", {29'd0, bus.fill_level}, 32'd4);
    check_eq("ovf_set", {31'd0, bus.overflow}, 32'd1);
    rd();
    check_eq("ovf_first", bus.user_r_data, 32'hA1);
    check_eq("ovf_nfull", {31'd0, bus.user_w_full}, 32'd0);
    check_eq("ovf_fill3", {29'd0, bus.fill_level}, 32'd3);

    // Simultaneous read and write
    rd(); check_eq("sim_pre", bus.user_r_data, 32'hA2);
    bus.user_r_rden = 1'b1;
    wr(32'hB1);
    bus.user_r_rden = 1'b0;
    check_eq("sim2_data", bus.user_r_data, 32'hA3);
    check_eq("sim2_fill", {29'd0, bus.fill_level}, 32'd2);
    rd(); check_eq("sim_a4", bus.user_r_data, 32'hA4);
    rd(); check_eq("sim_b1", bus.user_r_data, 32'hB1);
    bus.user_r_rden = 1'b1;
    wr(32'hC1);
    bus.user_r_rden = 1'b0;
    check_eq("sim0_fill", {29'd0, bus.fill_level}, 32'd1);
    check_eq("sim0_data", bus.user_r_data, 32'hB1);
    check_eq("sim0_nempty", {31'd0, bus.user_r_empty}, 32'd0);
    rd(); check_eq("sim0_c1", bus.user_r_data, 32'hC1);

    // EOF generation
    wr(32'hD1); wr(32'hD2);
    bus.user_w_open = 1'b0;
    tick();
    check_eq("eof_drain0", {31'd0, bus.user_r_eof}, 32'd0);
    rd();
    check_eq("eof_d1", bus.user_r_data, 32'hD1);
    check_eq("eof_drain1", {31'd0, bus.user_r_eof}, 32'd0);
    rd();
    check_eq("eof_d2", bus.user_r_data, 32'hD2);
    check_eq("eof_set", {31'd0, bus.user_r_eof}, 32'd1);
    check_eq("eof_empty", {31'd0, bus.user_r_empty}, 32'd1);
    bus.user_w_open = 1'b1;
    tick();
    check_eq("eof_clear", {31'd0, bus.user_r_eof}, 32'd0);

    // Flush on read-file close
    wr(32'hE1); wr(32'hE2); wr(32'hE3);
    bus.user_w_open = 1'b0;
    tick();
    bus.user_r_open = 1'b0;
    tick();
    check_eq("fl_fill", {29'd0, bus.fill_level}, 32'd0);
    check_eq("fl_empty", {31'd0, bus.user_r_empty}, 32'd1);
    check_eq("fl_eof", {31'd0, bus.user_r_eof}, 32'd0);
    check_eq("fl_ovf_kept", {31'd0, bus.overflow}, 32'd1);

    // Pointer wrap over 2*DEPTH+1 words
    bus.user_r_open = 1'b1;
    bus.user_w_open = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      wr(32'hF0 + i);
      rd();
      check_eq($sformatf("wrap_%0d", i), bus.user_r_data, 32'hF0 + i);
    end
    check_eq("wrap_empty", {31'd0, bus.user_r_empty}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
